// File: rtl/n64_response_assembler.sv
// N64 controller response assembler: collects MSB-first data bits plus a stop bit into a frame word.
// Optional gap timeout is compiled in with `define N64_ASM_TIMEOUT_EN.
module n64_response_assembler #(
   parameter int FRAME_BITS     = 32,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  read_data_bit,
   input  logic                  read_bit_data_valid,
   input  logic                  frame_ack,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic                  timeout_err,
   output logic                  overrun,
   output logic                  busy,
   output logic [5:0]            bit_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

   state_t                r_state;
   logic [FRAME_BITS-1:0] r_shift;
   logic [FRAME_BITS-1:0] r_frame_data;
   logic                  r_frame_valid;
   logic                  r_frame_err;
   logic                  r_overrun;
   logic                  r_busy;
   logic [5:0]            r_bit_count;

   assign frame_data  = r_frame_data;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign overrun     = r_overrun;
   assign busy        = r_busy;
   assign bit_count   = r_bit_count;

`ifdef N64_ASM_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [GAP_W-1:0] r_gap;
   logic             r_timeout_err;
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_frame_data  <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun     <= 1'b0;
         r_busy        <= 1'b0;
         r_bit_count   <= '0;
`ifdef N64_ASM_TIMEOUT_EN
         r_gap         <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         // Ack clears first; a completion later in this block overrides it.
         if (frame_ack) begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef N64_ASM_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
         end

`ifdef N64_ASM_TIMEOUT_EN
         if (read_bit_data_valid) begin
            r_gap <= '0;
         end else if (r_state != IDLE) begin
            if (r_gap == GAP_W'(TIMEOUT_CYCLES - 1)) begin
               r_timeout_err <= 1'b1;
               r_state       <= IDLE;
               r_busy        <= 1'b0;
               r_gap         <= '0;
            end else begin
               r_gap <= r_gap + 1'b1;
            end
         end
`endif

         if (read_bit_data_valid) begin
            case (r_state)
               IDLE: begin
                  r_shift     <= {{(FRAME_BITS-1){1'b0}}, read_data_bit};
                  r_bit_count <= 6'd1;
                  r_busy      <= 1'b1;
                  r_state     <= SHIFT;
               end
               SHIFT: begin
                  r_shift     <= {r_shift[FRAME_BITS-2:0], read_data_bit};
                  r_bit_count <= r_bit_count + 6'd1;
                  if (r_bit_count == 6'(FRAME_BITS - 1))
                     r_state <= STOP;
               end
               STOP: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  if (!r_frame_valid || frame_ack) begin
                     r_frame_data  <= r_shift;
                     r_frame_valid <= 1'b1;
                  end else begin
                     r_overrun <= 1'b1;
                  end
                  if (!read_data_bit)
                     r_frame_err <= 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_n64_response_assembler.sv
module tb_n64_response_assembler;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        read_data_bit = 1'b0;
   logic        read_bit_data_valid = 1'b0;
   logic        frame_ack = 1'b0;
   logic [31:0] frame_data;
   logic        frame_valid, frame_err, timeout_err, overrun, busy;
   logic [5:0]  bit_count;

   n64_response_assembler #(.FRAME_BITS(32), .TIMEOUT_CYCLES(2000)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .read_data_bit(read_data_bit),
      .read_bit_data_valid(read_bit_data_valid), .frame_ack(frame_ack),
      .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
      .timeout_err(timeout_err), .overrun(overrun), .busy(busy), .bit_count(bit_count)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   typedef struct {
      int          due;
      string       name;
      logic [42:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask

   task automatic expect_at(input int due, input string name, input logic [31:0] d,
                            input logic v, input logic fe, input logic te, input logic ov,
                            input logic bz, input logic [5:0] cnt);
      exp_t e;
      e.due  = due;
      e.name = name;
      e.exp  = {d, v, fe, te, ov, bz, cnt};
      q.push_back(e);
   endtask

   task automatic strobe(input logic b, input int gap, input logic a, output int at);
      read_data_bit       = b;
      read_bit_data_valid = 1'b1;
      frame_ack           = a;
      tick;
      at                  = cyc;
      read_bit_data_valid = 1'b0;
      frame_ack           = 1'b0;
      repeat (gap - 1) tick;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n, input int gap, output int last);
      logic [31:0] v;
      v = w;
      for (int i = n - 1; i >= 0; i--) strobe(v[i], gap, 1'b0, last);
   endtask

   task automatic do_ack;
      frame_ack = 1'b1;
      tick;
      frame_ack = 1'b0;
   endtask

   always @(negedge PCLK) begin
      logic [42:0] act;
      act = {frame_data, frame_valid, frame_err, timeout_err, overrun, busy, bit_count};
      while (q.size() > 0 && q[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL %s: check cycle %0d passed unsampled (now %0d)", q[0].name, q[0].due, cyc);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         checks++;
         if (act !== q[0].exp) begin
            errors++;
            $display("FAIL %s: got data=%h v=%b fe=%b te=%b ov=%b busy=%b cnt=%0d, want data=%h v=%b fe=%b te=%b ov=%b busy=%b cnt=%0d",
                     q[0].name, act[42:11], act[10], act[9], act[8], act[7], act[6], act[5:0],
                     q[0].exp[42:11], q[0].exp[10], q[0].exp[9], q[0].exp[8], q[0].exp[7],
                     q[0].exp[6], q[0].exp[5:0]);
         end
         void'(q.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d, want completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      int s;

      PRESET = 1'b1;
      read_bit_data_valid = 1'b1;
      read_data_bit = 1'b1;
      tick;
      tick;
      read_bit_data_valid = 1'b0;
      checks++;
      if (frame_data !== 32'h0 || frame_valid !== 1'b0 || busy !== 1'b0 || bit_count !== 6'd0) begin
         errors++;
         $display("FAIL reset_direct: got data=%h v=%b busy=%b cnt=%0d, want all zero",
                  frame_data, frame_valid, busy, bit_count);
      end
      expect_at(cyc, "reset", 32'h0, 0, 0, 0, 0, 0, 6'd0);
      PRESET = 1'b0;
      tick;

      send_bits(32'h80007F80, 32, 400, s);
      expect_at(cyc, "a_pre", 32'h0, 0, 0, 0, 0, 1, 6'd32);
      strobe(1'b1, 1, 1'b0, at);
      checks++;
      if (frame_valid !== 1'b1 || frame_data !== 32'h80007F80 || bit_count !== 6'd32) begin
         errors++;
         $display("FAIL a_direct: got data=%h v=%b cnt=%0d, want data=80007f80 v=1 cnt=32",
                  frame_data, frame_valid, bit_count);
      end
      expect_at(at, "a_done", 32'h80007F80, 1, 0, 0, 0, 0, 6'd32);
      do_ack;
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL a_ack_direct: got v=%b, want v=0", frame_valid);
      end
      expect_at(cyc, "a_ack", 32'h80007F80, 0, 0, 0, 0, 0, 6'd32);

      send_bits(32'h00000001, 32, 2, s);
      strobe(1'b0, 1, 1'b0, at);
      checks++;
      if (frame_err !== 1'b1 || frame_valid !== 1'b1) begin
         errors++;
         $display("FAIL b_direct: got fe=%b v=%b, want fe=1 v=1", frame_err, frame_valid);
      end
      expect_at(at, "b_err", 32'h00000001, 1, 1, 0, 0, 0, 6'd32);
      do_ack;
      expect_at(cyc, "b_ack", 32'h00000001, 0, 0, 0, 0, 0, 6'd32);

      send_bits(32'h11111111, 32, 2, s);
      strobe(1'b1, 1, 1'b0, at);
      expect_at(at, "c_first", 32'h11111111, 1, 0, 0, 0, 0, 6'd32);
      send_bits(32'h22222222, 32, 2, s);
      strobe(1'b1, 1, 1'b0, at);
      checks++;
      if (overrun !== 1'b1 || frame_data !== 32'h11111111) begin
         errors++;
         $display("FAIL c_ovr_direct: got ov=%b data=%h, want ov=1 data=11111111", overrun, frame_data);
      end
      expect_at(at, "c_ovr", 32'h11111111, 1, 0, 0, 1, 0, 6'd32);
      send_bits(32'h33333333, 32, 2, s);
      strobe(1'b1, 1, 1'b1, at);
      checks++;
      if (frame_data !== 32'h33333333 || frame_valid !== 1'b1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL c_win_direct: got data=%h v=%b ov=%b, want data=33333333 v=1 ov=0",
                  frame_data, frame_valid, overrun);
      end
      expect_at(at, "c_win", 32'h33333333, 1, 0, 0, 0, 0, 6'd32);
      do_ack;
      expect_at(cyc, "c_ack", 32'h33333333, 0, 0, 0, 0, 0, 6'd32);

      send_bits(32'h000002AB, 10, 2, s);
`ifdef N64_ASM_TIMEOUT_EN
      expect_at(s + 1999, "d_pre", 32'h33333333, 0, 0, 0, 0, 1, 6'd10);
      expect_at(s + 2000, "d_tout", 32'h33333333, 0, 0, 1, 0, 0, 6'd10);
      while (cyc < s + 2002) tick;
      do_ack;
      expect_at(cyc, "d_ack", 32'h33333333, 0, 0, 0, 0, 0, 6'd10);
`else
      expect_at(s + 1999, "d_pre", 32'h33333333, 0, 0, 0, 0, 1, 6'd10);
      expect_at(s + 10000, "d_hold", 32'h33333333, 0, 0, 0, 0, 1, 6'd10);
      while (cyc < s + 10001) tick;
`endif

      send_bits(32'h000ABCDE, 20, 2, s);
      PRESET = 1'b1;
      tick;
      expect_at(cyc, "e_rst", 32'h0, 0, 0, 0, 0, 0, 6'd0);
      PRESET = 1'b0;
      tick;
      send_bits(32'hA5A5A5A5, 32, 2, s);
      strobe(1'b1, 1, 1'b0, at);
      checks++;
      if (frame_data !== 32'hA5A5A5A5 || frame_err !== 1'b0 || timeout_err !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL e_direct: got data=%h fe=%b te=%b ov=%b, want data=a5a5a5a5 no flags",
                  frame_data, frame_err, timeout_err, overrun);
      end
      expect_at(at, "e_done", 32'hA5A5A5A5, 1, 0, 0, 0, 0, 6'd32);

      repeat (5) tick;
      while (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: never sampled (due %0d, now %0d)", q[0].name, q[0].due, cyc);
         void'(q.pop_front());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
